// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data memory.
// Each access is grant -> RAM access -> one-cycle hit; data wins unless fetch is starved.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready,
    output logic              ram_err,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] IACC = 2'd1;
    localparam logic [1:0] DACC = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT - 1);

    logic [1:0]        state_q,      state_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic [9:0]        tmo_cnt_q,    tmo_cnt_d;
    logic              ihit_q,       ihit_d;
    logic              dhit_q,       dhit_d;
    logic [DATA_W-1:0] iload_q,      iload_d;
    logic [DATA_W-1:0] dload_q,      dload_d;
    logic              ram_ren_q,    ram_ren_d;
    logic              ram_wen_q,    ram_wen_d;
    logic [ADDR_W-1:0] ramaddr_q,    ramaddr_d;
    logic [DATA_W-1:0] ramstore_q,   ramstore_d;
    logic              ram_err_q,    ram_err_d;
    logic              busy_q,       busy_d;

    logic d_req;
    logic fetch_starved;

    assign d_req         = dREN | dWEN;
    assign fetch_starved = iREN && (starve_cnt_q == STARVE_LIM);

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        ihit_d       = 1'b0;
        dhit_d       = 1'b0;
        iload_d      = iload_q;
        dload_d      = dload_q;
        ram_ren_d    = ram_ren_q;
        ram_wen_d    = ram_wen_q;
        ramaddr_d    = ramaddr_q;
        ramstore_d   = ramstore_q;
        ram_err_d    = ram_err_q;
        busy_d       = busy_q;

        // Fetch waiting is the only thing that keeps the starvation count alive.
        if (!iREN) begin
            starve_cnt_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (d_req && !fetch_starved) begin
                    state_d    = DACC;
                    ram_wen_d  = dWEN;
                    ram_ren_d  = ~dWEN;
                    ramaddr_d  = daddr;
                    ramstore_d = dstore;
                    busy_d     = 1'b1;
                    tmo_cnt_d  = '0;
                    if (iREN && starve_cnt_q != STARVE_LIM) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (iREN) begin
                    state_d      = IACC;
                    ram_ren_d    = 1'b1;
                    ram_wen_d    = 1'b0;
                    ramaddr_d    = iaddr;
                    ramstore_d   = dstore;
                    busy_d       = 1'b1;
                    tmo_cnt_d    = '0;
                    starve_cnt_d = '0;
                end
            end

            IACC, DACC: begin
                if (ram_ready) begin
                    if (state_q == IACC) begin
                        iload_d = ramload;
                    end else if (!ram_wen_q) begin
                        dload_d = ramload;
                    end
                    ram_ren_d = 1'b0;
                    ram_wen_d = 1'b0;
                    tmo_cnt_d = '0;
                    state_d   = DONE;
                    ihit_d    = (state_q == IACC);
                    dhit_d    = (state_q == DACC);
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Abandon the access; the still-held request is re-arbitrated from IDLE.
                    ram_err_d = 1'b1;
                    ram_ren_d = 1'b0;
                    ram_wen_d = 1'b0;
                    tmo_cnt_d = '0;
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 10'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                ram_ren_d = 1'b0;
                ram_wen_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            ihit_q       <= 1'b0;
            dhit_q       <= 1'b0;
            iload_q      <= '0;
            dload_q      <= '0;
            ram_ren_q    <= 1'b0;
            ram_wen_q    <= 1'b0;
            ramaddr_q    <= '0;
            ramstore_q   <= '0;
            ram_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            ihit_q       <= ihit_d;
            dhit_q       <= dhit_d;
            iload_q      <= iload_d;
            dload_q      <= dload_d;
            ram_ren_q    <= ram_ren_d;
            ram_wen_q    <= ram_wen_d;
            ramaddr_q    <= ramaddr_d;
            ramstore_q   <= ramstore_d;
            ram_err_q    <= ram_err_d;
            busy_q       <= busy_d;
        end
    end

    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ramREN   = ram_ren_q;
    assign ramWEN   = ram_wen_q;
    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;
    assign ram_err  = ram_err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;
    localparam int TO = 8;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          iREN = 1'b0;
    logic [AW-1:0] iaddr = '0;
    logic          ihit;
    logic [DW-1:0] iload;
    logic          dREN = 1'b0;
    logic          dWEN = 1'b0;
    logic [AW-1:0] daddr = '0;
    logic [DW-1:0] dstore = '0;
    logic          dhit;
    logic [DW-1:0] dload;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload = '0;
    logic          ram_ready = 1'b0;
    logic          ram_err;
    logic          busy;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM), .TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready),
        .ram_err(ram_err), .busy(busy)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the RAM port, how long it has waited,
    // and whose hit is due; expected outputs are what must be visible after each edge.
    int          m_owner;   // 0 none, 1 fetch, 2 data
    bit          m_write;
    int          m_waited;  // access cycles spent so far
    int          m_hit;     // side whose hit is showing this cycle
    int          m_starve;  // data wins in a row while fetch waited
    logic        e_ihit, e_dhit, e_ren, e_wen, e_err, e_busy;
    logic [31:0] e_iload, e_dload, e_addr, e_store;

    function automatic void m_reset();
        m_owner = 0; m_write = 1'b0; m_waited = 0; m_hit = 0; m_starve = 0;
        e_ihit = 1'b0; e_dhit = 1'b0; e_ren = 1'b0; e_wen = 1'b0;
        e_err = 1'b0; e_busy = 1'b0;
        e_iload = '0; e_dload = '0; e_addr = '0; e_store = '0;
    endfunction

    function automatic void m_step();
        int showing;
        showing = m_hit;
        m_hit  = 0;
        e_ihit = 1'b0;
        e_dhit = 1'b0;
        if (showing != 0) begin
            e_busy = 1'b0;          // the hit cycle never grants
        end else if (m_owner == 0) begin
            if ((dREN || dWEN) && !(iREN && m_starve == SM)) begin
                m_owner = 2;
                m_write = dWEN;
                e_addr  = daddr;
                if (iREN) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
            end else if (iREN) begin
                m_owner  = 1;
                m_write  = 1'b0;
                e_addr   = iaddr;
                m_starve = 0;
            end
            if (m_owner != 0) begin
                e_store  = dstore;
                e_ren    = !m_write;
                e_wen    = m_write;
                e_busy   = 1'b1;
                m_waited = 0;
            end
        end else begin
            m_waited++;
            if (ram_ready) begin
                if (m_owner == 1) e_iload = ramload;
                else if (!m_write) e_dload = ramload;
                e_ren  = 1'b0;
                e_wen  = 1'b0;
                m_hit  = m_owner;
                e_ihit = (m_owner == 1);
                e_dhit = (m_owner == 2);
                m_owner = 0;
            end else if (m_waited == TO) begin
                e_err   = 1'b1;
                e_ren   = 1'b0;
                e_wen   = 1'b0;
                e_busy  = 1'b0;
                m_owner = 0;
            end
        end
        if (!iREN) m_starve = 0;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) m_reset();
        else m_step();
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("ihit",     32'(ihit),   32'(e_ihit));
            check("dhit",     32'(dhit),   32'(e_dhit));
            check("iload",    iload,       e_iload);
            check("dload",    dload,       e_dload);
            check("ramREN",   32'(ramREN), 32'(e_ren));
            check("ramWEN",   32'(ramWEN), 32'(e_wen));
            check("ramaddr",  ramaddr,     e_addr);
            check("ramstore", ramstore,    e_store);
            check("ram_err",  32'(ram_err), 32'(e_err));
            check("busy",     32'(busy),   32'(e_busy));
            if (ihit && dhit) check("both_hits", 32'd1, 32'd0);
        end
    end

    task automatic quiet(input int n);
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    int seq[6];
    int nhits;
    int dead;
    int r;

    initial begin
        m_reset();
        repeat (2) @(negedge CLK);
        chk_en = 1'b1;
        check("rst_busy",   32'(busy),    32'd0);
        check("rst_ramREN", 32'(ramREN),  32'd0);
        check("rst_err",    32'(ram_err), 32'd0);
        nRST = 1'b1;
        quiet(2);

        // Single fetch
        $display("txn: single fetch iaddr=0x40");
        iREN = 1'b1; iaddr = 32'h40;
        @(negedge CLK);
        check("fetch_ramaddr", ramaddr, 32'h40);
        check("fetch_ramREN", 32'(ramREN), 32'd1);
        ram_ready = 1'b1; ramload = 32'h8C220004;
        @(negedge CLK);
        check("fetch_ihit", 32'(ihit), 32'd1);
        check("fetch_iload", iload, 32'h8C220004);
        iREN = 1'b0; ram_ready = 1'b0;
        @(negedge CLK);
        check("fetch_busy_after", 32'(busy), 32'd0);
        quiet(2);

        // Data beats fetch when both request together
        $display("txn: priority daddr=0x100 vs iaddr=0x80");
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h100;
        @(negedge CLK);
        check("prio_ramaddr_d", ramaddr, 32'h100);
        ram_ready = 1'b1; ramload = 32'h11112222;
        @(negedge CLK);
        check("prio_dhit", 32'(dhit), 32'd1);
        check("prio_dload", dload, 32'h11112222);
        dREN = 1'b0; ram_ready = 1'b0;
        @(negedge CLK);
        check("prio_idle_busy", 32'(busy), 32'd0);
        @(negedge CLK);
        check("prio_ramaddr_i", ramaddr, 32'h80);
        ram_ready = 1'b1; ramload = 32'h33334444;
        @(negedge CLK);
        check("prio_ihit", 32'(ihit), 32'd1);
        quiet(3);

        // Write takes precedence over read
        $display("txn: write daddr=0x200 dstore=0xDEADBEEF");
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
        @(negedge CLK);
        check("wr_ramWEN", 32'(ramWEN), 32'd1);
        check("wr_ramREN", 32'(ramREN), 32'd0);
        check("wr_ramstore", ramstore, 32'hDEADBEEF);
        ram_ready = 1'b1; ramload = 32'hBADBAD00;
        @(negedge CLK);
        check("wr_dhit", 32'(dhit), 32'd1);
        check("wr_dload_kept", dload, 32'h11112222);
        quiet(3);

        // Starvation: four data wins, then fetch forced, then data again
        $display("txn: starvation run");
        iREN = 1'b1; dREN = 1'b1; ram_ready = 1'b1;
        nhits = 0;
        for (int c = 0; c < 60 && nhits < 6; c++) begin
            @(negedge CLK);
            if (dhit) begin seq[nhits] = 2; nhits++; end
            else if (ihit) begin seq[nhits] = 1; nhits++; end
        end
        check("starve_hit_count", 32'(nhits), 32'd6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("starve_seq%0d", k), 32'(seq[k]), (k == 4) ? 32'd1 : 32'd2);
        end
        quiet(3);

        // Timeout: RAM never answers
        $display("txn: timeout daddr=0x300");
        dREN = 1'b1; daddr = 32'h300;
        for (int k = 1; k <= TO; k++) begin
            @(negedge CLK);
            check($sformatf("tmo_ren_c%0d", k), 32'(ramREN), 32'd1);
        end
        @(negedge CLK);
        check("tmo_ren_dropped", 32'(ramREN), 32'd0);
        check("tmo_err", 32'(ram_err), 32'd1);
        check("tmo_nohit", 32'(dhit), 32'd0);
        @(negedge CLK);
        check("tmo_regrant", 32'(ramREN), 32'd1);
        ram_ready = 1'b1;
        @(negedge CLK);
        check("tmo_retry_dhit", 32'(dhit), 32'd1);
        quiet(2);
        check("tmo_err_sticky", 32'(ram_err), 32'd1);

        // Reset in the middle of a data access
        $display("txn: reset mid-access daddr=0x400");
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h400;
        @(negedge CLK);
        check("mid_ramWEN_pre", 32'(ramWEN), 32'd1);
        #2 nRST = 1'b0;
        #1;
        check("mid_ramWEN_async", 32'(ramWEN), 32'd0);
        check("mid_busy_async", 32'(busy), 32'd0);
        check("mid_err_cleared", 32'(ram_err), 32'd0);
        dREN = 1'b0; dWEN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        check("mid_no_dhit", 32'(dhit), 32'd0);
        quiet(2);

        // Randomized traffic, checked by the model every cycle
        $display("txn: random traffic");
        dead = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLK);
            if (iREN) begin
                if (ihit) begin iREN = ($urandom_range(0, 3) != 0); iaddr = $urandom; end
                else if ($urandom_range(0, 49) == 0) iREN = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                iREN = 1'b1; iaddr = $urandom;
            end
            if (dREN || dWEN) begin
                if (dhit || $urandom_range(0, 49) == 0) begin dREN = 1'b0; dWEN = 1'b0; end
            end else if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 3);
                dWEN = (r <= 1);
                dREN = (r != 0);
                daddr = $urandom; dstore = $urandom;
            end
            if (dead > 0) begin
                ram_ready = 1'b0; dead--;
            end else begin
                if ($urandom_range(0, 59) == 0) dead = $urandom_range(4, 12);
                ram_ready = ($urandom_range(0, 9) < 6);
            end
            ramload = $urandom;
        end
        quiet(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
